// File: rtl/multdiv_iterative.sv
// Iterative signed multiply/divide unit: radix-2 Booth multiply and restoring
// divide on magnitudes, one step per clock, fixed WIDTH-cycle latency.
module multdiv_iterative #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [TAG_W-1:0] tag_in,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy,
    output logic [TAG_W-1:0] tag_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] counter;
    logic [WIDTH-1:0] opnd;        // multiplicand for MUL, |divisor| for DIV
    logic [WIDTH-1:0] acc_hi;      // Booth upper half / division remainder
    logic [WIDTH-1:0] acc_lo;      // Booth lower half / dividend-quotient shifter
    logic             acc_q;       // Booth q(-1) bit
    logic             neg_q;
    logic             div_zero;
    logic             div_ovf;
    logic [TAG_W-1:0] tag_r;

    logic             start_mul, start_div, last_step;

    logic signed [WIDTH:0] booth_sum;
    logic [WIDTH-1:0]      mul_hi_nxt, mul_lo_nxt;
    logic                  mul_q_nxt;
    logic [WIDTH:0]        div_shift, div_trial;
    logic [WIDTH-1:0]      div_rem_nxt, div_quo_nxt;

    // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1) unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    // Product overflows when the upper word is not the sign extension of the lower word.
    function automatic logic mul_overflow(input logic [WIDTH-1:0] hi, input logic [WIDTH-1:0] lo);
        return hi != {WIDTH{lo[WIDTH-1]}};
    endfunction

    // Apply the quotient sign and the divide-by-zero override.
    function automatic logic [WIDTH-1:0] div_signed(input logic [WIDTH-1:0] q, input logic neg,
                                                    input logic zero);
        if (zero) return '0;
        return neg ? (~q + 1'b1) : q;
    endfunction

    assign start_mul      = ctrl_MULT & ~ctrl_DIV;
    assign start_div      = ctrl_DIV & ~ctrl_MULT;
    assign last_step      = (counter == LAST_STEP);
    assign busy           = (state == MUL) || (state == DIV);
    assign data_resultRDY = (state == DONE);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; a valid start pulse overrides whatever is in flight.
    always_comb begin
        state_nxt = state;
        case (state)
            MUL:     if (last_step) state_nxt = DONE;
            DIV:     if (last_step) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = state;
        endcase
        if (start_mul)      state_nxt = MUL;
        else if (start_div) state_nxt = DIV;
    end

    // One Booth step: add/subtract on a sign-extended upper half, then arithmetic shift right.
    always_comb begin
        booth_sum = $signed({acc_hi[WIDTH-1], acc_hi});
        case ({acc_lo[0], acc_q})
            2'b01:   booth_sum = booth_sum + $signed({opnd[WIDTH-1], opnd});
            2'b10:   booth_sum = booth_sum - $signed({opnd[WIDTH-1], opnd});
            default: booth_sum = booth_sum;
        endcase
        mul_hi_nxt = booth_sum[WIDTH:1];
        mul_lo_nxt = {booth_sum[0], acc_lo[WIDTH-1:1]};
        mul_q_nxt  = acc_lo[0];
    end

    // One restoring-division step: shift in the next dividend bit, keep the trial if non-negative.
    always_comb begin
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd};
        if (!div_trial[WIDTH]) begin
            div_rem_nxt = div_trial[WIDTH-1:0];
            div_quo_nxt = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            div_rem_nxt = div_shift[WIDTH-1:0];
            div_quo_nxt = {acc_lo[WIDTH-2:0], 1'b0};
        end
    end

    // Operand capture, iteration and result registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            counter        <= '0;
            opnd           <= '0;
            acc_hi         <= '0;
            acc_lo         <= '0;
            acc_q          <= 1'b0;
            neg_q          <= 1'b0;
            div_zero       <= 1'b0;
            div_ovf        <= 1'b0;
            tag_r          <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            tag_out        <= '0;
        end else if (start_mul) begin
            counter  <= '0;
            opnd     <= data_operandA;
            acc_hi   <= '0;
            acc_lo   <= data_operandB;
            acc_q    <= 1'b0;
            neg_q    <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
            tag_r    <= tag_in;
        end else if (start_div) begin
            counter  <= '0;
            opnd     <= magnitude(data_operandB);
            acc_hi   <= '0;
            acc_lo   <= magnitude(data_operandA);
            acc_q    <= 1'b0;
            neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero <= (data_operandB == '0);
            div_ovf  <= (data_operandA == MIN_VAL) && (data_operandB == '1);
            tag_r    <= tag_in;
        end else if (state == MUL) begin
            counter <= counter + CNT_W'(1);
            acc_hi  <= mul_hi_nxt;
            acc_lo  <= mul_lo_nxt;
            acc_q   <= mul_q_nxt;
            if (last_step) begin
                data_result    <= mul_lo_nxt;
                data_exception <= mul_overflow(mul_hi_nxt, mul_lo_nxt);
                tag_out        <= tag_r;
            end
        end else if (state == DIV) begin
            counter <= counter + CNT_W'(1);
            acc_hi  <= div_rem_nxt;
            acc_lo  <= div_quo_nxt;
            if (last_step) begin
                data_result    <= div_signed(div_quo_nxt, neg_q, div_zero);
                data_exception <= div_zero | div_ovf;
                tag_out        <= tag_r;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_iterative.sv
// Scoreboard bench for multdiv_iterative: expected results are queued at issue
// and compared, including latency, whenever the unit strobes data_resultRDY.
module tb_multdiv_iterative;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        logic [4:0]  tag;
        int          start;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [4:0]  tag_in = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;
    logic [4:0]  tag_out;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    multdiv_iterative #(.WIDTH(32), .TAG_W(5)) dut (
        .clock(clock),
        .reset(reset),
        .ctrl_MULT(ctrl_MULT),
        .ctrl_DIV(ctrl_DIV),
        .data_operandA(data_operandA),
        .data_operandB(data_operandB),
        .tag_in(tag_in),
        .data_result(data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
        .busy(busy),
        .tag_out(tag_out)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] tag, input int s);
        exp_t   e;
        longint p;
        int     ai, bi, q;
        e.tag   = tag;
        e.start = s;
        if (!is_div) begin
            p     = longint'($signed(a)) * longint'($signed(b));
            e.res = p[31:0];
            e.exc = (p != longint'($signed(p[31:0])));
        end else if (b == 32'h0) begin
            e.res = 32'h0;
            e.exc = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.res = 32'h8000_0000;
            e.exc = 1'b1;
        end else begin
            ai    = a;
            bi    = b;
            q     = ai / bi;
            e.res = q;
            e.exc = 1'b0;
        end
        return e;
    endfunction

    // Drive a start pulse for one edge; caller positions this before the intended start edge.
    task automatic start_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] tag);
        ctrl_MULT     = !is_div;
        ctrl_DIV      = is_div;
        data_operandA = a;
        data_operandB = b;
        tag_in        = tag;
        exp_q.push_back(model(is_div, a, b, tag, cyc + 1));
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        tag_in        = 5'($urandom);
    endtask

    task automatic wait_drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(posedge clock);
            k++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 64'(exp_q.size()), 64'(0));
            exp_q.delete();
        end
        #1;
    endtask

    task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag);
        @(posedge clock);
        #1;
        start_op(is_div, a, b, tag);
        wait_drain();
    endtask

    // Scoreboard: every completion strobe must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (reset && data_resultRDY) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rdy", 64'(1), 64'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", 64'(data_result), 64'(e.res));
                check("exception", 64'(data_exception), 64'(e.exc));
                check("tag", 64'(tag_out), 64'(e.tag));
                check("latency", 64'(cyc - e.start), 64'(32));
                check("busy_at_rdy", 64'(busy), 64'(0));
            end
        end
    end

    initial begin
        bit k;
        // Reset state
        #2;
        check("rst_result", 64'(data_result), 64'(0));
        check("rst_rdy", 64'(data_resultRDY), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_tag", 64'(tag_out), 64'(0));
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;

        // 7 * -3, with busy tracked across the whole operation and a one-cycle RDY pulse
        @(posedge clock);
        #1;
        start_op(1'b0, 32'd7, 32'hFFFF_FFFD, 5'd9);
        for (int i = 0; i < 32; i++) begin
            @(negedge clock);
            check("busy_inflight", 64'(busy), 64'(1));
        end
        @(negedge clock);
        check("rdy_high", 64'(data_resultRDY), 64'(1));
        @(negedge clock);
        check("rdy_pulse", 64'(data_resultRDY), 64'(0));
        check("result_hold", 64'(data_result), 64'(32'hFFFF_FFEB));
        wait_drain();

        // Multiply boundaries
        run_op(1'b0, 32'h0001_0000, 32'h0001_0000, 5'd1);
        run_op(1'b0, 32'h8000_0000, 32'd1, 5'd2);
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 5'd3);
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5);

        // Divide boundaries
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 5'd6);
        run_op(1'b1, 32'd5, 32'd0, 5'd7);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
        run_op(1'b1, 32'h8000_0000, 32'd1, 5'd10);
        run_op(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 5'd11);
        run_op(1'b1, 32'd3, 32'hFFFF_FFF9, 5'd12);

        // Random operands
        for (int i = 0; i < 8; i++) begin
            k = 1'($urandom);
            run_op(k, $urandom, (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom,
                   5'($urandom));
        end

        // Restart: MUL 6*7 aborted by DIV 100/7 issued at the tenth edge
        @(posedge clock);
        #1;
        start_op(1'b0, 32'd6, 32'd7, 5'd13);
        repeat (9) @(posedge clock);
        #1;
        void'(exp_q.pop_back());
        start_op(1'b1, 32'd100, 32'd7, 5'd4);
        wait_drain();

        // Asynchronous reset in the middle of an operation
        @(posedge clock);
        #1;
        start_op(1'b0, 32'd12345, 32'd678, 5'd14);
        repeat (14) @(posedge clock);
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("arst_result", 64'(data_result), 64'(0));
        check("arst_exception", 64'(data_exception), 64'(0));
        check("arst_rdy", 64'(data_resultRDY), 64'(0));
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_tag", 64'(tag_out), 64'(0));
        @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (40) @(posedge clock);
        #1;
        run_op(1'b0, 32'd3, 32'd3, 5'd15);

        // Both start pulses together from IDLE: ignored
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b1;
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd9;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        @(negedge clock);
        check("both_busy", 64'(busy), 64'(0));
        repeat (40) @(posedge clock);
        #1;
        check("both_busy_late", 64'(busy), 64'(0));

        // New start in the same cycle as RDY
        @(posedge clock);
        #1;
        start_op(1'b0, 32'hFFFF_FF00, 32'd77, 5'd16);
        begin
            int w = 0;
            @(negedge clock);
            while (!data_resultRDY && w < 60) begin
                @(negedge clock);
                w++;
            end
            check("rdy_seen", 64'(data_resultRDY), 64'(1));
        end
        start_op(1'b1, 32'hFFFF_FC18, 32'd7, 5'd17);
        wait_drain();
        @(negedge clock);
        check("final_idle", 64'(busy), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d cycles, expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multdiv_iterative.md
Name: multdiv_iterative

Overview:
- Multi-cycle signed multiply/divide unit beside the execute stage of the 5-stage pipeline.
- Execute issues a one-cycle start pulse with the bypassed operands and the destination register tag.
- The unit iterates for a fixed 32 cycles, then presents result, exception flag and tag for one cycle to the X/M writeback path.
- Pipeline stall control holds dependent instructions while busy=1.

Parameters:
WIDTH, 32, operand/result width; counter and latency scale with it (latency = WIDTH cycles)
TAG_W, 5, width of destination-register tag carried alongside the operation

Ports:
clock  input  1  master clock, rising-edge
reset  input  1  asynchronous, active-low; 0 forces the reset state immediately
ctrl_MULT  input  1  one-cycle start pulse: signed A*B
ctrl_DIV  input  1  one-cycle start pulse: signed A/B
data_operandA  input  WIDTH  multiplicand / dividend, sampled on start edge only
data_operandB  input  WIDTH  multiplier / divisor, sampled on start edge only
tag_in  input  TAG_W  destination register, sampled on start edge
data_result  output  WIDTH  product low word or quotient; valid while data_resultRDY=1
data_exception  output  1  overflow / divide-by-zero flag; valid while data_resultRDY=1
data_resultRDY  output  1  one-cycle completion strobe
busy  output  1  operation in flight (stall request to pipeline)
tag_out  output  TAG_W  tag of the completing operation; valid while data_resultRDY=1

Behaviour:
- Reset (reset=0, async): state=IDLE; data_result=0, data_exception=0, data_resultRDY=0, busy=0, tag_out=0, counter=0, internal operand/accumulator regs=0. Applies mid-operation; the in-flight op is discarded with no RDY.
- States: IDLE, MUL, DIV, DONE. 6-bit iteration counter.
- Start rule: at a rising edge E0 with exactly one of ctrl_MULT/ctrl_DIV high, latch A, B, tag_in; clear counter; enter MUL or DIV; busy=1 after E0.
- Both start pulses high at the same edge: request ignored, state unchanged.
- Restart: a valid start while in MUL/DIV/DONE aborts the current op (no RDY for it) and begins the new one exactly as from IDLE.
- MUL: radix-2 Booth over a 2*WIDTH+1 accumulator, one step per edge E1..E32.
- DIV: restoring division on magnitudes (|A|, |B|), one quotient bit per edge E1..E32; sign applied at completion.
- At edge E32: enter DONE; drive data_result, data_exception, tag_out; data_resultRDY=1 and busy=0 for exactly the cycle after E32.
- Latency from start edge to RDY-high edge: exactly WIDTH (32) edges, independent of operand values.
- DONE -> IDLE at the next edge unless a new start arrives (then -> MUL/DIV). RDY drops to 0. data_result, data_exception and tag_out hold their values until the next completion or reset.
- Multiply result: low WIDTH bits of the exact 64-bit signed product. data_exception=1 iff the 64-bit product is not the sign-extension of its low word.
- Divide result: signed quotient truncated toward zero; remainder discarded.
- Divide by B=0: result=0, data_exception=1 (still full 32-cycle latency).
- Divide 0x80000000 / -1: result=0x80000000, data_exception=1.
- Operand inputs are ignored outside start edges; the upstream stage may change them freely while busy.

Test Plan:
- ctrl_MULT with A=7, B=-3, tag=9 -> exactly 32 edges later RDY=1 one cycle, result=0xFFFFFFEB, exception=0, tag_out=9; busy high for the 32 intervening cycles.
- ctrl_MULT with A=0x00010000, B=0x00010000 -> result=0x00000000, exception=1. Also A=0x80000000, B=1 -> result=0x80000000, exception=0.
- ctrl_DIV with A=-7, B=2 -> result=0xFFFFFFFD (-3), exception=0. A=5, B=0 -> result=0, exception=1. A=0x80000000, B=-1 -> result=0x80000000, exception=1.
- Start MUL (6*7); at edge E10 issue DIV 100/7 with tag=4 -> no RDY for the MUL; RDY 32 edges after the DIV start with result=14, tag_out=4.
- Pull reset low at cycle 15 of an op -> all outputs 0 immediately (before the next clock edge); no RDY afterwards. After release, a fresh MUL 3*3 -> result=9 at the correct latency.
- Both ctrl_MULT and ctrl_DIV high for one edge from IDLE -> busy stays 0 and no RDY within 40 cycles. A start pulse in the same cycle as RDY (DONE) launches the new op correctly.
